// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush (selected fields kept), and a saturating downstream-stall counter.
// Build option: define PIPE_STAGE_SKID_EN for a one-entry skid buffer and an in_ready registered away from out_ready.
module pipe_stage_reg #(
    parameter int                    DATA_W     = 32,
    parameter int                    NUM_FIELDS = 5,
    parameter logic [NUM_FIELDS-1:0] KEEP_MASK  = NUM_FIELDS'(1),
    parameter int                    CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]             stall_cnt
);
    localparam int PAYLOAD_W = NUM_FIELDS * DATA_W;

    logic [PAYLOAD_W-1:0] flush_data;
    logic                 in_xfer;
    logic                 out_free;
    logic                 stalled;

    // Fields marked in KEEP_MASK survive a squash; the rest are cleared.
    always_comb begin
        flush_data = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (KEEP_MASK[k]) begin
                flush_data[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_free = !out_valid || out_ready;
    assign stalled  = out_valid && !out_ready;
    assign in_xfer  = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_valid;
    logic [PAYLOAD_W-1:0] skid_data;

    // NOTE: in_ready depends only on registered skid state plus rst/flush, so out_ready never reaches it.
    assign in_ready = !rst && !flush && !skid_valid;

    // NOTE: all state updates here are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_data   <= flush_data;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !rst && !flush && out_free;

    // NOTE: all state updates here are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= flush_data;
        end else if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stalled && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model compared every cycle,
// directed literal cases, then randomized traffic with flushes and async resets.
module tb_pipe_stage_reg;
    localparam int DATA_W     = 32;
    localparam int NUM_FIELDS = 5;
    localparam int PW         = DATA_W * NUM_FIELDS;
    localparam int CNT_W      = 16;
    localparam int CNT_W_S    = 4;
    localparam logic [NUM_FIELDS-1:0] KEEP = 5'b00001;
    localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;
    localparam int unsigned CNT_MAX_S = (1 << CNT_W_S) - 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_data   = '0;

    logic               in_ready, out_valid, in_ready_s, out_valid_s;
    logic [PW-1:0]      out_data, out_data_s;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W_S-1:0] stall_cnt_s;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W_S)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .flush(flush), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .stall_cnt(stall_cnt_s)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of payloads (capacity 1, or 2 with the skid build).
    logic [PW-1:0] q[$];
    logic [PW-1:0] m_data  = '0;
    int unsigned   m_cnt   = 0;
    int unsigned   m_cnt_s = 0;
    bit            m_acc, m_stall;

    function automatic logic [PW-1:0] keep_fields(input logic [PW-1:0] d);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (KEEP[k]) r[k*DATA_W +: DATA_W] = d[k*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    function automatic bit m_in_ready();
        if (rst || flush) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || out_ready;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_data  = '0;
            m_cnt   = 0;
            m_cnt_s = 0;
        end else begin
            m_acc   = in_valid && m_in_ready();
            m_stall = q.size() > 0 && !out_ready;
            if (flush) begin
                q.delete();
                m_data = keep_fields(in_data);
            end else begin
                if (m_stall) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (m_cnt_s < CNT_MAX_S) m_cnt_s++;
                end
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (m_acc) q.push_back(in_data);
                if (q.size() > 0) m_data = q[0];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_in_ready());
            check("out_valid", out_valid, q.size() > 0);
            check("out_data", out_data, m_data);
            check("stall_cnt", stall_cnt, m_cnt);
            check("stall_cnt_w4", stall_cnt_s, m_cnt_s);
        end
    end

    function automatic logic [PW-1:0] mk(input logic [31:0] v);
        return PW'(v);
    endfunction

    function automatic logic [PW-1:0] all_fields(input logic [31:0] v);
        logic [PW-1:0] r;
        for (int k = 0; k < NUM_FIELDS; k++) r[k*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_stall_cnt", stall_cnt, '0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Back-to-back streaming, one-cycle latency, no bubbles.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, mk(i), 1'b1, 1'b0);
            tick();
            check("stream_valid", out_valid, 1'b1);
            check("stream_data", out_data, mk(i));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("stream_drain_valid", out_valid, 1'b0);
        check("stream_drain_hold", out_data, mk(8));

        // Flush keeps field 0 from in_data, clears the rest.
        drive(1'b1, all_fields(32'hA), 1'b1, 1'b0);
        tick();
        check("flush_pre_valid", out_valid, 1'b1);
        check("flush_pre_data", out_data, all_fields(32'hA));
        drive(1'b0, mk(32'h40) | (all_fields(32'hB) & ~mk(32'hFFFF_FFFF)), 1'b0, 1'b1);
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick();
        check("flush_valid", out_valid, 1'b0);
        check("flush_data", out_data, mk(32'h40));

        // Stall counting and saturation.
        do_reset();
        drive(1'b1, mk(32'h1234_5678), 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, all_fields($urandom()), 1'b0, 1'b0);
            tick();
        end
        check("stall_cnt_20", stall_cnt, 20);
        check("stall_cnt_sat15", stall_cnt_s, 15);
        check("stall_data_stable", out_data, mk(32'h1234_5678));
        check("stall_valid", out_valid, 1'b1);

`ifdef PIPE_STAGE_SKID_EN
        // Two payloads accepted under back-pressure, delivered in order.
        do_reset();
        drive(1'b1, mk(1), 1'b0, 1'b0);
        #1;
        check("skid_rdy_first", in_ready, 1'b1);
        tick();
        check("skid_first_out", out_data, mk(1));
        drive(1'b1, mk(2), 1'b0, 1'b0);
        #1;
        check("skid_rdy_second", in_ready, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("skid_full_rdy", in_ready, 1'b0);
        check("skid_hold_first", out_data, mk(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("skid_deliver_second_v", out_valid, 1'b1);
        check("skid_deliver_second", out_data, mk(2));
        tick();
        check("skid_empty_valid", out_valid, 1'b0);
        check("skid_empty_hold", out_data, mk(2));
`endif

        // Asynchronous reset between edges.
        do_reset();
        drive(1'b1, mk(77), 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) tick();
        check("arst_pre_cnt", stall_cnt, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_cnt", stall_cnt, '0);
        check("arst_data", out_data, '0);
        check("arst_in_ready", in_ready, 1'b0);
        rst = 1'b0;

        // Flush beats a simultaneous input and output transfer.
        tick();
        drive(1'b1, mk(9), 1'b1, 1'b0);
        tick();
        check("simul_pre_valid", out_valid, 1'b1);
        drive(1'b1, mk(32'h55), 1'b1, 1'b1);
        #1;
        check("simul_in_ready", in_ready, 1'b0);
        tick();
        check("simul_valid", out_valid, 1'b0);
        check("simul_data", out_data, mk(32'h55));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("simul_no_accept", out_valid, 1'b0);

        // Randomized traffic with stall bursts, flushes and occasional async resets.
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ((n % 64) < 32) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < NUM_FIELDS; k++) in_data[k*DATA_W +: DATA_W] = $urandom();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            tick();
        end

        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of one payload field.
REQ-002 The block SHALL have parameter NUM_FIELDS, default 5, giving the number of payload fields.
REQ-003 The block SHALL have parameter KEEP_MASK, NUM_FIELDS bits, default 1 (field 0 only), marking the fields that still load on flush.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents a payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: this stage accepts the payload this cycle.
REQ-009 The block SHALL have port in_data, input, NUM_FIELDS*DATA_W bits: the payload; field k occupies bits [k*DATA_W +: DATA_W].
REQ-010 The block SHALL have port flush, input, 1 bit: squash the contents of this stage.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the stage holds a valid payload.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the payload.
REQ-013 The block SHALL have port out_data, output, NUM_FIELDS*DATA_W bits: the registered payload.
REQ-014 The block SHALL have port stall_cnt, output, CNT_W bits: the saturating count of downstream-stall cycles.

Function
REQ-015 An input transfer SHALL occur on a rising edge where in_valid && in_ready && !flush.
REQ-016 An output transfer SHALL occur on a rising edge where out_valid && out_ready.
REQ-017 in_ready SHALL be 0 while flush is 1, and otherwise follow REQ-033 or REQ-034.
REQ-018 On an input transfer with the output register empty or transferring, in_data SHALL load into out_data, with out_valid=1 on the next cycle and a latency of 1 cycle.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold unchanged.
REQ-020 On an output transfer with no input transfer and no buffered entry, out_valid SHALL go to 0 and out_data SHALL hold.
REQ-021 On a flush edge, out_valid SHALL go to 0 and any skid entry SHALL be discarded.
REQ-022 On a flush edge, fields with KEEP_MASK[k]=1 SHALL load in_data field k regardless of in_valid, and all other fields SHALL load 0.
REQ-023 Flush SHALL take priority over a simultaneous input transfer, output transfer or stall.
REQ-024 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready && !flush.
REQ-025 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Payloads SHALL leave the stage in acceptance order, with none dropped or duplicated except on flush.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for a clock edge, set out_valid=0, out_data=0 and stall_cnt=0, and empty the skid entry.
REQ-028 While rst=1, in_ready SHALL be 0.
REQ-029 A reset asserted mid-transfer SHALL discard all payloads in the stage.
REQ-030 The first transfer after rst deasserts SHALL behave exactly as described under Function.

Configuration
REQ-031 The macro PIPE_STAGE_SKID_EN SHALL select between a combinational and a registered in_ready.
REQ-032 PIPE_STAGE_SKID_EN SHALL affect only REQ-033 and REQ-034; all other requirements SHALL hold in both builds.
REQ-033 With PIPE_STAGE_SKID_EN defined:
- a one-entry skid register SHALL be present;
- in_ready SHALL equal !skid_valid, registered with no combinational path from out_ready;
- an input accepted while the output is stalled SHALL go to the skid register;
- on the next output transfer, the skid entry SHALL move to out_data.
REQ-034 With PIPE_STAGE_SKID_EN undefined:
- no skid register SHALL be present;
- in_ready SHALL equal !out_valid || out_ready.

Verification
REQ-035 Bench case, back-to-back streaming: defaults, in_valid=1 and out_ready=1 for 8 cycles with field0 = 1..8 -> out_data field0 SHALL show 1..8 on consecutive cycles, each 1 cycle after input, with no bubbles.
REQ-036 Bench case, flush with keep: out_valid=1 holding {5 fields = 0xA}, then flush=1 with in_data field0=0x40, others 0xB -> out_valid=0, field0=0x40, fields 1-4 = 0.
REQ-037 Bench case, stall count: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=20 and out_data stable; with CNT_W=4 and 20 stall cycles -> stall_cnt=15.
REQ-038 Bench case, skid (PIPE_STAGE_SKID_EN defined): hold out_ready=0 while sending 0x1, 0x2 -> both accepted, in_ready=0 afterwards; release out_ready -> 0x1 then 0x2 delivered in order.
REQ-039 Bench case, async reset: assert rst between clock edges while out_valid=1 -> out_valid=0 and stall_cnt=0 before the next edge.
REQ-040 Bench case, simultaneous events: flush=1, in_valid=1, out_ready=1 on the same edge -> no input transfer, out_valid=0 next cycle.
